// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: func3 codes, FSM states,
// byte-lane enables and request legality helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Illegal func3 for the direction, or a misaligned half/word access.
    function automatic logic req_bad(input logic write, input logic [2:0] f3,
                                     input logic [1:0] lo);
        logic legal;
        case (f3)
            F3_B:    legal = 1'b1;
            F3_BU:   legal = !write;
            F3_H:    legal = (lo[0] == 1'b0);
            F3_HU:   legal = !write && (lo[0] == 1'b0);
            F3_W:    legal = (lo == 2'b00);
            default: legal = 1'b0;
        endcase
        return !legal;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            F3_B:    be = BE_BYTE0 << lo;
            F3_H:    be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
            F3_W:    be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    // Replicate store data so every enabled lane sees its little-endian byte.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: picks the addressed lane(s) out of a RAM word
// and sign- or zero-extends them according to func3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] shifted_s;

    assign shifted_s = word_i >> {addr_lo_i, 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    // Extend the selected lane(s) to 32 bits.
    always_comb begin
        data_o = 32'd0;
        case (func3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data_o = {24'd0, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   data_o = {16'd0, half_s};
            F3_W:    data_o = word_i;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the MEM stage: one request at a time, a fixed
// number of wait cycles, then a single response beat with data or error.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int CNT_W = $clog2(LATENCY + 2);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              lo_q, lo_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [2:0]              func3_q, func3_d;
    logic                    err_q, err_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;
    logic                    resp_error_q, resp_error_d;

    logic [31:0]             mem_q [0:(2**ADDR_WIDTH)-1];

    logic                    req_err_s;
    logic                    access_s;
    logic                    mem_we_s;
    logic [3:0]              be_s;
    logic [31:0]             st_data_s;
    logic [31:0]             rword_s;
    logic [31:0]             load_data_s;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

    assign req_err_s = req_bad(req_write, req_func3, req_addr[1:0])
                     || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    assign access_s  = (state_q == ST_WAIT) && (cnt_q == {CNT_W{1'b0}}) && !err_q;
    assign mem_we_s  = access_s && write_q;
    assign be_s      = byte_en(func3_q, lo_q);
    assign st_data_s = store_data(func3_q, wdata_q);
    assign rword_s   = mem_q[idx_q];

    load_extend u_load_extend (
        .word_i    (rword_s),
        .addr_lo_i (lo_q),
        .func3_i   (func3_q),
        .data_o    (load_data_s)
    );

    // Byte-lane RAM write; reset on the access edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_q][8*b +: 8] <= st_data_s[8*b +: 8];
                end
            end
        end
    end

    // FSM, captured request and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            write_q      <= 1'b0;
            idx_q        <= {ADDR_WIDTH{1'b0}};
            lo_q         <= 2'b00;
            wdata_q      <= 32'd0;
            func3_q      <= 3'b000;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            lo_q         <= lo_d;
            wdata_q      <= wdata_d;
            func3_q      <= func3_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Next-state logic. A failed check still passes through WAIT with a zero
    // count so the error beat appears one cycle after acceptance.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        lo_d         = lo_q;
        wdata_d      = wdata_q;
        func3_d      = func3_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[ADDR_WIDTH+1:2];
                    lo_d    = req_addr[1:0];
                    wdata_d = req_wdata;
                    func3_d = req_func3;
                    err_d   = req_err_s;
                    cnt_d   = req_err_s ? {CNT_W{1'b0}} : CNT_W'(LATENCY);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = err_q;
                    resp_rdata_d = (err_q || write_q) ? 32'd0 : load_data_s;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_WIDTH=10, LATENCY=2).
module tb_dmem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_func3  (req_func3),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Called 1ns after a rising edge with the DUT idle; returns when idle again.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd,
                        output logic er, output int lat);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_func3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_error;
        if (!resp_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc, last, low_cnt, resp_cnt, err_cnt;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_func3 = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", {31'd0, resp_error}, 32'd0);

        // Word store then load, with latency
        xfer(1'b1, 32'h10, 32'hDEADBEEF, F3_W, rd, er, lat);
        check("sw_lat", lat, 32'd3);
        check("sw_err", {31'd0, er}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("sw_one_beat", {31'd0, resp_valid}, 32'd0);
        xfer(1'b0, 32'h10, 32'd0, F3_W, rd, er, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_lat", lat, 32'd3);

        // Sub-word loads
        xfer(1'b0, 32'h13, 32'd0, F3_B, rd, er, lat);
        check("lb_13", rd, 32'hFFFFFFDE);
        xfer(1'b0, 32'h13, 32'd0, F3_BU, rd, er, lat);
        check("lbu_13", rd, 32'h000000DE);
        xfer(1'b0, 32'h12, 32'd0, F3_H, rd, er, lat);
        check("lh_12", rd, 32'hFFFFDEAD);
        xfer(1'b0, 32'h10, 32'd0, F3_HU, rd, er, lat);
        check("lhu_10", rd, 32'h0000BEEF);

        // Sub-word stores
        xfer(1'b1, 32'h12, 32'h00001234, F3_H, rd, er, lat);
        xfer(1'b1, 32'h10, 32'hFFFFFF55, F3_B, rd, er, lat);
        xfer(1'b0, 32'h10, 32'd0, F3_W, rd, er, lat);
        check("sh_sb_merge", rd, 32'h1234BE55);

        // Error cases
        xfer(1'b0, 32'h11, 32'd0, F3_W, rd, er, lat);
        check("lw_mis_err", {31'd0, er}, 32'd1);
        check("lw_mis_lat", lat, 32'd1);
        check("lw_mis_rd", rd, 32'd0);
        xfer(1'b1, 32'h13, 32'h0000AAAA, F3_H, rd, er, lat);
        check("sh_mis_err", {31'd0, er}, 32'd1);
        check("sh_mis_lat", lat, 32'd1);
        xfer(1'b0, 32'h10, 32'd0, 3'b011, rd, er, lat);
        check("f3_011_err", {31'd0, er}, 32'd1);
        check("f3_011_rd", rd, 32'd0);
        xfer(1'b1, 32'h00001000, 32'h77777777, F3_W, rd, er, lat);
        check("sw_oor_err", {31'd0, er}, 32'd1);
        check("sw_oor_lat", lat, 32'd1);
        xfer(1'b1, 32'h11, 32'h000000AA, F3_BU, rd, er, lat);
        check("sbu_err", {31'd0, er}, 32'd1);
        xfer(1'b0, 32'h10, 32'd0, F3_W, rd, er, lat);
        check("after_err_word", rd, 32'h1234BE55);
        check("after_err_ok", {31'd0, er}, 32'd0);

        // Continuous req_valid: one accept per LATENCY+3 cycles
        req_valid = 1'b1; req_write = 1'b1; req_func3 = F3_W;
        acc = 0; last = -1; low_cnt = 0; resp_cnt = 0; err_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            req_addr  = 32'h40 + 32'(acc * 4);
            req_wdata = 32'hA0000000 + 32'(acc);
            if (resp_valid) resp_cnt++;
            if (resp_error) err_cnt++;
            if (req_ready) begin
                if (last >= 0) check("accept_gap", c - last, 32'd5);
                last = c;
                acc++;
            end else begin
                low_cnt++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("stream_accepts", acc, 32'd3);
        check("stream_ready_low", low_cnt, 32'd12);
        check("stream_resps", resp_cnt, 32'd3);
        check("stream_errs", err_cnt, 32'd0);
        xfer(1'b0, 32'h40, 32'd0, F3_W, rd, er, lat);
        check("stream_w0", rd, 32'hA0000000);
        xfer(1'b0, 32'h44, 32'd0, F3_W, rd, er, lat);
        check("stream_w1", rd, 32'hA0000001);
        xfer(1'b0, 32'h48, 32'd0, F3_W, rd, er, lat);
        check("stream_w2", rd, 32'hA0000002);

        // Reset during WAIT drops the store
        xfer(1'b1, 32'h20, 32'h11111111, F3_W, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_func3 = F3_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_busy", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        check("mid_rst_error", {31'd0, resp_error}, 32'd0);
        resp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (resp_valid) resp_cnt++;
        end
        check("mid_rst_no_resp", resp_cnt, 32'd0);
        xfer(1'b0, 32'h20, 32'd0, F3_W, rd, er, lat);
        check("mid_rst_word", rd, 32'h11111111);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
